// File: rtl/ordena_n_num_seq_if.sv
// Input/output stream bundle for ordena_n_num_seq.
// The out_idx tag exists only when SORT_INDEX_EN is defined.
interface ordena_n_num_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
`ifdef SORT_INDEX_EN
  logic [IW-1:0]    out_idx;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
`ifdef SORT_INDEX_EN
    input  out_idx,
`endif
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
`ifdef SORT_INDEX_EN
    output out_idx,
`endif
    output out_last
  );
endinterface

// File: rtl/ordena_n_num_seq.sv
// Serial N-element odd-even transposition sorter with stream in/out.
// Optional arrival-index tags are enabled by defining SORT_INDEX_EN.
module ordena_n_num_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ena,
  input  logic                i_cresc_ou_decres,
  output logic                o_busy,
  ordena_n_num_seq_if.slave   bus
);
  localparam int unsigned   IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_elem [N];
  logic [IW-1:0]    r_cnt;
  logic [IW-1:0]    r_pass;
  logic             r_mode;

  logic [WIDTH-1:0] w_src [N];
  logic [WIDTH-1:0] w_nxt [N];
  logic             w_odd;
  logic             w_swap;
  logic             w_in_fire;
  logic             w_out_fire;

`ifdef SORT_INDEX_EN
  logic [IW-1:0]    r_tag     [N];
  logic [IW-1:0]    w_src_tag [N];
  logic [IW-1:0]    w_nxt_tag [N];
`endif

  assign bus.in_ready  = i_ena && (r_state == StLoad);
  assign bus.out_valid = i_ena && (r_state == StDrain);
  assign bus.out_data  = (r_state == StDrain) ? r_elem[r_cnt] : '0;
  assign bus.out_last  = (r_state == StDrain) && (r_cnt == LastIdx);
  assign o_busy        = (r_state != StLoad);
`ifdef SORT_INDEX_EN
  assign bus.out_idx   = (r_state == StDrain) ? r_tag[r_cnt] : '0;
`endif

  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_out_fire = bus.out_valid && bus.out_ready;

  // The final load folds pass 0 onto the vector with the new element inserted,
  // so SORT needs only passes 1..N-1 and drain starts N cycles after the last accept.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_src[i] = r_elem[i];
`ifdef SORT_INDEX_EN
      w_src_tag[i] = r_tag[i];
`endif
    end
    if (r_state == StLoad) begin
      w_src[r_cnt] = bus.in_data;
`ifdef SORT_INDEX_EN
      w_src_tag[r_cnt] = r_cnt;
`endif
    end
    w_odd  = (r_state == StLoad) ? 1'b0 : r_pass[0];
    w_swap = 1'b0;
    w_nxt  = w_src;
`ifdef SORT_INDEX_EN
    w_nxt_tag = w_src_tag;
`endif
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (i[0] == w_odd) begin
        // Strict compare keeps equal values in place, so the sort is stable.
        w_swap = r_mode ? (w_src[i] > w_src[i+1]) : (w_src[i] < w_src[i+1]);
        if (w_swap) begin
          w_nxt[i]   = w_src[i+1];
          w_nxt[i+1] = w_src[i];
`ifdef SORT_INDEX_EN
          w_nxt_tag[i]   = w_src_tag[i+1];
          w_nxt_tag[i+1] = w_src_tag[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StLoad;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_mode  <= 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        r_elem[i] <= '0;
`ifdef SORT_INDEX_EN
        r_tag[i]  <= '0;
`endif
      end
    end else if (i_ena) begin
      case (r_state)
        StLoad: begin
          if (w_in_fire) begin
            if (r_cnt == '0) begin
              r_mode <= i_cresc_ou_decres;
            end
            if (r_cnt == LastIdx) begin
              r_elem  <= w_nxt;
`ifdef SORT_INDEX_EN
              r_tag   <= w_nxt_tag;
`endif
              r_cnt   <= '0;
              r_pass  <= IW'(1);
              r_state <= StSort;
            end else begin
              r_elem <= w_src;
`ifdef SORT_INDEX_EN
              r_tag  <= w_src_tag;
`endif
              r_cnt  <= r_cnt + IW'(1);
            end
          end
        end
        StSort: begin
          r_elem <= w_nxt;
`ifdef SORT_INDEX_EN
          r_tag  <= w_nxt_tag;
`endif
          if (r_pass == LastIdx) begin
            r_pass  <= '0;
            r_cnt   <= '0;
            r_state <= StDrain;
          end else begin
            r_pass <= r_pass + IW'(1);
          end
        end
        StDrain: begin
          if (w_out_fire) begin
            if (r_cnt == LastIdx) begin
              r_cnt   <= '0;
              r_state <= StLoad;
            end else begin
              r_cnt <= r_cnt + IW'(1);
            end
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end
endmodule

// File: tb/tb_ordena_n_num_seq.sv
// Self-checking bench for ordena_n_num_seq (N=8, WIDTH=8) against a stable
// insertion-sort reference; out_idx is checked when SORT_INDEX_EN is defined.
module tb_ordena_n_num_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic cresc = 1'b1;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   fire_cyc = 0;

  logic [7:0] fv    [8];
  logic [7:0] exp_d [8];
  logic [2:0] exp_i [8];

  ordena_n_num_seq_if #(.WIDTH(8), .N(8)) bus ();

  ordena_n_num_seq #(.WIDTH(8), .N(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_ena             (ena),
    .i_cresc_ou_decres (cresc),
    .o_busy            (busy),
    .bus               (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Stable insertion sort of fv; ties keep arrival order in either direction.
  task automatic model(input bit mode);
    logic [7:0] d  [8];
    logic [2:0] ix [8];
    for (int i = 0; i < 8; i++) begin
      d[i]  = fv[i];
      ix[i] = 3'(i);
    end
    for (int i = 1; i < 8; i++) begin
      int j;
      logic [7:0] kd;
      logic [2:0] ki;
      j  = i;
      kd = d[i];
      ki = ix[i];
      while (j > 0 && (mode ? (d[j-1] > kd) : (d[j-1] < kd))) begin
        d[j]  = d[j-1];
        ix[j] = ix[j-1];
        j--;
      end
      d[j]  = kd;
      ix[j] = ki;
    end
    exp_d = d;
    exp_i = ix;
  endtask

  task automatic load_frame(input bit mode, input bit tog, input bit gaps, input bit stall);
    int k = 0;
    int guard = 0;
    bit stalled = 1'b0;
    while (k < 8 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (stall && k == 3 && !stalled) begin
        stalled = 1'b1;
        ena = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = fv[k];
        repeat (3) begin
          #1;
          chk("in_ready_stalled", 32'(bus.in_ready), 0);
          @(negedge clk);
        end
      end
      ena = 1'b1;
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data = fv[k];
      cresc = (k == 0) ? mode : (tog ? ~mode : mode);
      #1;
      chk("in_ready_load", 32'(bus.in_ready), 1);
      chk("busy_load", 32'(busy), 0);
      if (bus.in_valid && bus.in_ready) begin
        if (k == 7) fire_cyc = cyc;
        k++;
      end
    end
    if (k < 8) chk("load_timeout", 32'(k), 8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cresc = 1'($urandom);
  endtask

  task automatic drain(input bit rand_ready, input bit stall);
    int k = 0;
    int guard = 0;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    while (k < 8 && guard < 500) begin
      if (stall && k == 4 && !stalled) begin
        stalled = 1'b1;
        ena = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
          #1;
          chk("out_valid_stalled", 32'(bus.out_valid), 0);
          @(negedge clk);
        end
        ena = 1'b1;
      end
      bus.out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      if (!seen) begin
        if (bus.out_valid) begin
          seen = 1'b1;
          chk("latency", 32'(cyc - fire_cyc), 8);
        end else begin
          chk("busy_sort", 32'(busy), 1);
        end
      end
      if (seen) begin
        chk("out_valid", 32'(bus.out_valid), 1);
        chk("out_data", 32'(bus.out_data), 32'(exp_d[k]));
        chk("out_last", 32'(bus.out_last), 32'(k == 7));
`ifdef SORT_INDEX_EN
        chk("out_idx", 32'(bus.out_idx), 32'(exp_i[k]));
`endif
        if (bus.out_ready) k++;
      end
      @(negedge clk);
      guard++;
    end
    if (k < 8) chk("drain_timeout", 32'(k), 8);
    bus.out_ready = 1'b0;
    #1;
    chk("in_ready_after", 32'(bus.in_ready), 1);
    chk("busy_after", 32'(busy), 0);
    chk("out_valid_after", 32'(bus.out_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    ena = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    rst = 1'b0;

    // Directed ascending and descending (mode toggled mid-load).
    fv = '{8'd7, 8'd3, 8'd200, 8'd0, 8'd3, 8'd255, 8'd1, 8'd9};
    load_frame(1'b1, 1'b0, 1'b0, 1'b0);
    model(1'b1);
    drain(1'b0, 1'b0);
    load_frame(1'b0, 1'b1, 1'b0, 1'b0);
    model(1'b0);
    drain(1'b0, 1'b0);

    // Ties: stable order visible through out_idx.
    fv = '{8'd5, 8'd5, 8'd2, 8'd5, 8'd5, 8'd2, 8'd9, 8'd5};
    load_frame(1'b1, 1'b0, 1'b0, 1'b0);
    model(1'b1);
    drain(1'b0, 1'b0);
    load_frame(1'b0, 1'b1, 1'b0, 1'b0);
    model(1'b0);
    drain(1'b0, 1'b0);

    // Random frames with input gaps and 30% out_ready.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) fv[i] = 8'($urandom_range(0, (r % 2 == 1) ? 7 : 255));
      m = 1'($urandom);
      load_frame(m, 1'($urandom), 1'b1, 1'b0);
      model(m);
      drain(1'b1, 1'b0);
    end

    // Reset during SORT, then a fresh frame.
    for (int i = 0; i < 8; i++) fv[i] = 8'($urandom);
    load_frame(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 1);
    chk("rst_mid_out_data", 32'(bus.out_data), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) fv[i] = 8'($urandom);
    load_frame(1'b0, 1'b0, 1'b0, 1'b0);
    model(1'b0);
    drain(1'b1, 1'b0);

    // ena=0 for 3 cycles mid-load and mid-drain.
    for (int i = 0; i < 8; i++) fv[i] = 8'($urandom_range(0, 15));
    load_frame(1'b1, 1'b0, 1'b0, 1'b1);
    model(1'b1);
    drain(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
